// File: rtl/serial_sub.sv
// Bit-serial subtractor: one full-subtractor cell plus a borrow flop walk
// a - b - bin LSB first over WIDTH cycles behind a start/busy/done handshake.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_sa, r_sb, r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout, r_zero;

    logic             w_accept, w_last, w_d, w_borrow_nxt;
    logic [WIDTH-1:0] w_res_nxt;

    // A new request is taken in IDLE and also in DONE, giving back-to-back ops.
    assign w_accept     = start && (r_state != RUN);
    assign w_last       = (r_state == RUN) && (r_cnt == CW'(WIDTH - 1));
    assign w_d          = r_sa[0] ^ r_sb[0] ^ r_borrow;
    assign w_borrow_nxt = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_borrow);
    assign w_res_nxt    = {w_d, r_res[WIDTH-1:1]};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = start ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa     <= '0;
            r_sb     <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sa     <= a;
                r_sb     <= b;
                r_borrow <= bin;
                r_cnt    <= '0;
                r_res    <= '0;
            end else if (r_state == RUN) begin
                r_sa     <= r_sa >> 1;
                r_sb     <= r_sb >> 1;
                r_borrow <= w_borrow_nxt;
                r_res    <= w_res_nxt;
                r_cnt    <= r_cnt + 1'b1;
            end
            // Result registers move only on the completing edge.
            if (w_last) begin
                r_diff <= w_res_nxt;
                r_bout <= w_borrow_nxt;
                r_zero <= (w_res_nxt == '0);
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign diff = r_diff;
    assign bout = r_bout;
    assign zero = r_zero;
endmodule

// File: tb/tb_serial_sub.sv
// Directed and random checks of serial_sub at WIDTH=8 and WIDTH=16.
module tb_serial_sub;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, bin = 1'b0;
    logic [7:0]  a = '0, b = '0;
    logic        busy, done, bout, zero;
    logic [7:0]  diff;
    logic        start16 = 1'b0, bin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, bout16, zero16;
    logic [15:0] diff16;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .zero(zero));

    serial_sub #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .bin(bin16),
        .busy(busy16), .done(done16), .diff(diff16), .bout(bout16), .zero(zero16));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch one op on dut8 from IDLE; returns done latency in cycles after
    // the accepting edge (-1 on timeout) and the number of busy cycles seen.
    task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                        output int lat, output int bc);
        @(negedge clk);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = ~ia; b = ~ib; bin = ~ibin;
        lat = -1; bc = 0;
        for (int i = 1; i <= 40; i++) begin
            if (done) begin lat = i; break; end
            if (busy) bc++;
            @(negedge clk);
        end
    endtask

    task automatic run16(input logic [15:0] ia, input logic [15:0] ib, input logic ibin,
                         output int lat);
        @(negedge clk);
        a16 = ia; b16 = ib; bin16 = ibin; start16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0; a16 = ~ia; b16 = ~ib;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            if (done16) begin lat = i; break; end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [7:0] a, b;
        logic       bin;
        logic [7:0] diff;
        logic       bout, zero;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int lat, bc, nd;
        logic held;
        logic [8:0]  e9;
        logic [16:0] e17;

        vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset diff", diff, 0);
        chk("reset bout", bout, 0);
        chk("reset zero", zero, 0);

        foreach (vecs[k]) begin
            run8(vecs[k].a, vecs[k].b, vecs[k].bin, lat, bc);
            chk($sformatf("v%0d latency", k), lat, 9);
            chk($sformatf("v%0d busy cycles", k), bc, 8);
            chk($sformatf("v%0d diff", k), diff, vecs[k].diff);
            chk($sformatf("v%0d bout", k), bout, vecs[k].bout);
            chk($sformatf("v%0d zero", k), zero, vecs[k].zero);
        end

        // Start pulse during RUN must be ignored.
        @(negedge clk);
        a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            start = (i == 3);
            if (i == 3) a = 8'h99;
            if (done) begin start = 1'b0; lat = i; break; end
            @(negedge clk);
        end
        chk("ignored start latency", lat, 9);
        chk("ignored start diff", diff, 8'h0F);

        // Back-to-back: start held in the DONE cycle.
        a = 8'h05; b = 8'h07; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = 8'h00; b = 8'h00;
        chk("b2b accepted busy", busy, 1);
        held = 1'b1; lat = -1;
        for (int i = 1; i <= 40; i++) begin
            if (done) begin lat = i; break; end
            if (diff !== 8'h0F) held = 1'b0;
            @(negedge clk);
        end
        chk("b2b prior diff held", held, 1);
        chk("b2b latency", lat, 9);
        chk("b2b diff", diff, 8'hFE);
        chk("b2b bout", bout, 1);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("no extra done pulses", nd, 0);

        // Reset aborts a running op.
        @(negedge clk);
        a = 8'h40; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 4; i++) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort diff", diff, 0);
        chk("abort bout", bout, 0);
        chk("abort zero", zero, 0);
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk("abort no done", nd, 0);

        for (int n = 0; n < 1000; n++) begin
            logic [7:0] ra, rb;
            logic rbin;
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            e9 = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
            run8(ra, rb, rbin, lat, bc);
            chk($sformatf("rand8 %0h-%0h-%0b lat", ra, rb, rbin), lat, 9);
            chk($sformatf("rand8 %0h-%0h-%0b", ra, rb, rbin), {zero, bout, diff},
                {(e9[7:0] == 8'd0), e9});
        end

        for (int n = 0; n < 1000; n++) begin
            logic [15:0] ra, rb;
            logic rbin;
            ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
            if (n < 3) begin ra = 16'h0000; rb = 16'hFFFF; rbin = 1'b1; end
            e17 = {1'b0, ra} - {1'b0, rb} - {16'd0, rbin};
            run16(ra, rb, rbin, lat);
            chk($sformatf("rand16 %0h-%0h-%0b lat", ra, rb, rbin), lat, 17);
            chk($sformatf("rand16 %0h-%0h-%0b", ra, rb, rbin), {zero16, bout16, diff16},
                {(e17[15:0] == 16'd0), e17});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial ripple subtractor: computes a - b - bin over WIDTH cycles, LSB first, using one full-subtractor cell and a borrow flop.
- It is the inverse-direction companion of the team's full-adder cell.
- It sits beside the adder datapath as a low-area sequential subtract unit.
- A start/busy/done handshake is used. Results are held in output registers until the next operation completes.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  minuend; captured when start is accepted.
- b  input  WIDTH  subtrahend; captured when start is accepted.
- bin  input  1  borrow-in; captured when start is accepted.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  single-cycle pulse; results are valid from this cycle onward.
- diff  output  WIDTH  (a - b - bin) mod 2^WIDTH.
- bout  output  1  borrow-out; 1 iff a < b + bin, unsigned.
- zero  output  1  1 iff diff == 0.

Behaviour:
- Interface: one clock; reset is synchronous and active-high, port names clk and rst.
- Reset (rst=1 at an edge):
  - state goes to IDLE.
  - busy=0, done=0, diff=0, bout=0, zero=0.
  - Shift registers, bit counter and borrow flop are cleared.
  - rst has priority over start and over every other event.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at an edge does all of the following, then moves to RUN:
  - Loads shift registers sa<=a, sb<=b.
  - Sets borrow<=bin, cnt<=0 and clears the result shift register.
- RUN: each edge processes bit 0 of sa and sb with the current borrow:
  - d = sa[0] ^ sb[0] ^ borrow.
  - borrow_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow).
  - sa, sb shift right by 1; d shifts into the MSB of the result shift register; cnt increments.
  - On the edge where cnt == WIDTH-1, processing completes: diff<=final result, bout<=borrow_next, zero<=(final result == 0), state moves to DONE.
- DONE: lasts exactly one cycle with done=1, busy=0.
  - start=1 in this cycle is accepted exactly as in IDLE (back-to-back), and the state goes to RUN.
  - Otherwise the state returns to IDLE.
- Latency: start accepted at edge E0 gives done=1 in the cycle after edge E0+WIDTH. That is WIDTH+1 cycles from the accepting edge; throughput is one result per WIDTH+1 cycles.
- busy=1 exactly during the RUN state.
- start while busy=1 is ignored. The operands in flight are unaffected, and no request is queued.
- Input changes on a, b, bin after acceptance have no effect on the running operation.
- diff, bout and zero change only on the completing edge, or on reset. They hold their value through IDLE, the next RUN, and DONE until the next completion.
- rst during RUN aborts the operation: no done pulse, and outputs are zeroed per the reset rule.
- Arithmetic is purely unsigned modulo 2^WIDTH. {bout, diff} equals the (WIDTH+1)-bit two's-complement value of a - b - bin.

Test Plan (WIDTH=8 unless noted):
- a=0x35, b=0x12, bin=0, start pulse -> busy high for 8 cycles; done in the 9th cycle after the accepting edge; diff=0x23, bout=0, zero=0.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, zero=0. Then a=0x80, b=0x7F, bin=1 -> diff=0x00, bout=0, zero=1.
- a=0x00, b=0xFF, bin=1 -> diff=0x00, bout=1, zero=1 (full borrow ripple). Then a=0xFF, b=0x00, bin=0 -> diff=0xFF, bout=0.
- First op a=0x10, b=0x01. Pulse start again, with a=0x99, at RUN cycle 3 -> pulse ignored; result 0x0F; exactly one done pulse.
- start held high in the DONE cycle with a=0x05, b=0x07 -> new op accepted; prior outputs (diff=0x0F) held until the next done; then diff=0xFE, bout=1.
- rst asserted at RUN cycle 4 of a=0x40, b=0x01 -> next cycle busy=0, diff=0, bout=0, zero=0; done never pulses.
- 1000 random {a, b, bin} with WIDTH=8 and WIDTH=16 -> {bout, diff} matches the reference model a - b - bin every op.
